// File: rtl/vec_mul_pkg.sv
// Shared definitions for the vector-multiplier datapath control: scheduler
// state encodings, default datapath sizes and an elaboration-time clog2.
package vec_mul_pkg;

    localparam int DEF_MATRIX_SIZE    = 8;
    localparam int DEF_PARTIAL_SUM_BW = 20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((32'sd1 <<< result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sched_result_fifo.sv
// First-word-fall-through synchronous FIFO with an occupancy count; the head
// word reads as zero while the FIFO is empty.
module sched_result_fifo
    import vec_mul_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             valid_o,
    output logic [AW:0]      count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push_s, do_pop_s;

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    always_comb begin
        do_pop_s  = pop_i && (count_q != {(AW+1){1'b0}});
        do_push_s = push_i && ((count_q != (AW+1)'(DEPTH)) || do_pop_s);
        wr_ptr_d  = do_push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d  = do_pop_s ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are never visible while count is zero.
    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Head decode.
    always_comb begin
        valid_o = (count_q != {(AW+1){1'b0}});
        count_o = count_q;
        if (valid_o) begin
            rdata_o = mem_q[rd_ptr_q];
        end else begin
            rdata_o = {WIDTH{1'b0}};
        end
    end

endmodule

// File: rtl/adder_tree_sched.sv
// Row scheduler for the multiply/adder-tree datapath: credit-gated row issue,
// fixed-latency capture of the tree sum, and an in-order tagged result stream.
module adder_tree_sched
    import vec_mul_pkg::*;
#(
    parameter  int MATRIX_SIZE    = DEF_MATRIX_SIZE,
    parameter  int PARTIAL_SUM_BW = DEF_PARTIAL_SUM_BW,
    parameter  int PIPE_LAT       = 2,
    parameter  int FIFO_DEPTH     = 4,
    localparam int IW             = clog2(MATRIX_SIZE),
    localparam int CW             = clog2(FIFO_DEPTH) + 1,
    localparam int EW             = IW + PARTIAL_SUM_BW
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      row_en,
    output logic [IW-1:0]             row_idx,
    input  logic [PARTIAL_SUM_BW-1:0] tree_sum,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [PARTIAL_SUM_BW-1:0] res_data,
    output logic [IW-1:0]             res_row
);
    sched_state_e        state_q, state_d;
    logic [IW-1:0]       row_cnt_q, row_cnt_d;
    logic [PIPE_LAT-1:0] trk_vld_q, trk_vld_d;
    logic [IW-1:0]       trk_row_q [PIPE_LAT];
    logic [IW-1:0]       trk_row_d [PIPE_LAT];
    logic [31:0]         inflight_s;
    logic                issue_s;
    logic                last_row_s;
    logic [CW-1:0]       fifo_count_s;
    logic                fifo_pop_s;
    logic [EW-1:0]       fifo_wdata_s;
    logic [EW-1:0]       fifo_rdata_s;

    // Every tracked row already owns a FIFO slot, so credit counts both; all inputs are registered.
    always_comb begin
        inflight_s = 32'd0;
        for (int i = 0; i < PIPE_LAT; i++) begin
            inflight_s = inflight_s + {31'd0, trk_vld_q[i]};
        end
        issue_s    = (state_q == ISSUE) &&
                     ((32'(fifo_count_s) + inflight_s) < 32'(FIFO_DEPTH));
        last_row_s = (row_cnt_q == IW'(MATRIX_SIZE - 1));
    end

    // State and row-counter registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            row_cnt_q <= {IW{1'b0}};
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = ISSUE;
                    row_cnt_d = {IW{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (issue_s) begin
                    row_cnt_d = row_cnt_q + IW'(1);
                    state_d   = last_row_s ? DRAIN : ISSUE;
                end else begin
                    state_d = ISSUE;
                end
            end
            DRAIN: begin
                if ((inflight_s == 32'd0) && (fifo_count_s == {CW{1'b0}})) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        busy    = (state_q == ISSUE) || (state_q == DRAIN);
        done    = (state_q == DONE);
        row_en  = issue_s;
        row_idx = issue_s ? row_cnt_q : {IW{1'b0}};
    end

    // Tracker shift: tail takes this cycle's issue, head marks the row whose sum is on tree_sum now.
    always_comb begin
        trk_vld_d[0] = issue_s;
        trk_row_d[0] = row_cnt_q;
        for (int i = 1; i < PIPE_LAT; i++) begin
            trk_vld_d[i] = trk_vld_q[i-1];
            trk_row_d[i] = trk_row_q[i-1];
        end
    end

    // Tracker registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            trk_vld_q <= {PIPE_LAT{1'b0}};
            for (int i = 0; i < PIPE_LAT; i++) begin
                trk_row_q[i] <= {IW{1'b0}};
            end
        end else begin
            trk_vld_q <= trk_vld_d;
            for (int i = 0; i < PIPE_LAT; i++) begin
                trk_row_q[i] <= trk_row_d[i];
            end
        end
    end

    assign fifo_wdata_s = {trk_row_q[PIPE_LAT-1], tree_sum};
    assign fifo_pop_s   = res_valid && res_ready;

    sched_result_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk_i   (clk),
        .rstn_i  (rstn),
        .push_i  (trk_vld_q[PIPE_LAT-1]),
        .wdata_i (fifo_wdata_s),
        .pop_i   (fifo_pop_s),
        .rdata_o (fifo_rdata_s),
        .valid_o (res_valid),
        .count_o (fifo_count_s)
    );

    assign {res_row, res_data} = fifo_rdata_s;

endmodule

// File: tb/tb_adder_tree_sched.sv
// Self-checking bench for adder_tree_sched: a delay-line datapath model returns
// 3*row-5, and a scoreboard queue checks every result that leaves the FIFO.
module tb_adder_tree_sched;

    localparam int BW   = 20;
    localparam int MS_A = 8;
    localparam int PL_A = 2;
    localparam int FD_A = 4;
    localparam int IW_A = 3;
    localparam int MS_B = 32;
    localparam int PL_B = 1;
    localparam int FD_B = 2;
    localparam int IW_B = 5;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic            start_a = 1'b0, res_ready_a = 1'b0;
    logic            busy_a, done_a, row_en_a, res_valid_a;
    logic [IW_A-1:0] row_idx_a, res_row_a;
    logic [BW-1:0]   tree_sum_a, res_data_a;

    logic            start_b = 1'b0, res_ready_b = 1'b0;
    logic            busy_b, done_b, row_en_b, res_valid_b;
    logic [IW_B-1:0] row_idx_b, res_row_b;
    logic [BW-1:0]   tree_sum_b, res_data_b;

    int n_checks = 0;
    int n_fail   = 0;
    int issued_a, popped_a, done_cnt_a;
    logic [IW_A+BW-1:0] sb_a [$];
    logic [IW_B+BW-1:0] sb_b [$];

    adder_tree_sched #(.MATRIX_SIZE(MS_A), .PARTIAL_SUM_BW(BW), .PIPE_LAT(PL_A), .FIFO_DEPTH(FD_A)) dut_a (
        .clk(clk), .rstn(rstn), .start(start_a), .busy(busy_a), .done(done_a),
        .row_en(row_en_a), .row_idx(row_idx_a), .tree_sum(tree_sum_a),
        .res_valid(res_valid_a), .res_ready(res_ready_a), .res_data(res_data_a), .res_row(res_row_a)
    );

    adder_tree_sched #(.MATRIX_SIZE(MS_B), .PARTIAL_SUM_BW(BW), .PIPE_LAT(PL_B), .FIFO_DEPTH(FD_B)) dut_b (
        .clk(clk), .rstn(rstn), .start(start_b), .busy(busy_b), .done(done_b),
        .row_en(row_en_b), .row_idx(row_idx_b), .tree_sum(tree_sum_b),
        .res_valid(res_valid_b), .res_ready(res_ready_b), .res_data(res_data_b), .res_row(res_row_b)
    );

    // Datapath models: {valid, row} delay lines, sum = 3*row-5, junk when no row is due.
    logic [IW_A:0] dl_a [PL_A];
    logic [IW_B:0] dl_b [PL_B];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < PL_A; i++) dl_a[i] <= '0;
            for (int i = 0; i < PL_B; i++) dl_b[i] <= '0;
        end else begin
            dl_a[0] <= {row_en_a, row_idx_a};
            for (int i = 1; i < PL_A; i++) dl_a[i] <= dl_a[i-1];
            dl_b[0] <= {row_en_b, row_idx_b};
            for (int i = 1; i < PL_B; i++) dl_b[i] <= dl_b[i-1];
        end
    end

    assign tree_sum_a = dl_a[PL_A-1][IW_A] ? BW'(3 * int'(dl_a[PL_A-1][IW_A-1:0]) - 5) : 20'h5A5A5;
    assign tree_sum_b = dl_b[PL_B-1][IW_B] ? BW'(3 * int'(dl_b[PL_B-1][IW_B-1:0]) - 5) : 20'h5A5A5;

    task automatic clear_a();
        issued_a   = 0;
        popped_a   = 0;
        done_cnt_a = 0;
        sb_a.delete();
    endtask

    // One clock of DUT A: drive inputs just after the edge, observe at the falling edge.
    task automatic cycle_a(input logic st, input logic rdy);
        logic [IW_A+BW-1:0] exp_e;
        @(posedge clk);
        #1;
        start_a     = st;
        res_ready_a = rdy;
        @(negedge clk);
        if (row_en_a) begin
            n_checks++;
            if (issued_a >= MS_A || row_idx_a !== IW_A'(issued_a)) begin
                n_fail++;
                $display("FAIL issue_a: row_idx=%0d, expected row %0d (job has %0d rows)", row_idx_a, issued_a, MS_A);
            end
            sb_a.push_back({IW_A'(issued_a), BW'(3 * issued_a - 5)});
            issued_a++;
        end
        if (res_valid_a && res_ready_a) begin
            n_checks++;
            if (sb_a.size() == 0) begin
                n_fail++;
                $display("FAIL result_a: unexpected row=%0d data=%0d, expected none", res_row_a, $signed(res_data_a));
            end else begin
                exp_e = sb_a.pop_front();
                if ({res_row_a, res_data_a} !== exp_e) begin
                    n_fail++;
                    $display("FAIL result_a: row=%0d data=%0d, expected row=%0d data=%0d", res_row_a,
                             $signed(res_data_a), exp_e[IW_A+BW-1:BW], $signed(exp_e[BW-1:0]));
                end
            end
            popped_a++;
        end
        if (done_a) done_cnt_a++;
        if (row_en_a) begin
            n_checks++;
            if (issued_a - popped_a > FD_A) begin
                n_fail++;
                $display("FAIL overflow_a: outstanding=%0d, limit %0d", issued_a - popped_a, FD_A);
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        n_checks += 7;
        if (busy_a !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy_a); end
        if (done_a !== 1'b0)      begin n_fail++; $display("FAIL reset_done: got %b, expected 0", done_a); end
        if (row_en_a !== 1'b0)    begin n_fail++; $display("FAIL reset_row_en: got %b, expected 0", row_en_a); end
        if (row_idx_a !== 3'd0)   begin n_fail++; $display("FAIL reset_row_idx: got %0d, expected 0", row_idx_a); end
        if (res_valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b, expected 0", res_valid_a); end
        if (res_data_a !== 20'd0) begin n_fail++; $display("FAIL reset_res_data: got %h, expected 0", res_data_a); end
        if (res_row_a !== 3'd0)   begin n_fail++; $display("FAIL reset_res_row: got %0d, expected 0", res_row_a); end
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_free_flow();
        int first_en = -1, last_en = -1, en_cnt = 0, first_vld = -1;
        clear_a();
        for (int c = 0; c < 100 && done_cnt_a == 0; c++) begin
            cycle_a(c == 0, 1'b1);
            if (row_en_a) begin
                if (first_en < 0) first_en = c;
                last_en = c;
                en_cnt++;
            end
            if (res_valid_a && first_vld < 0) first_vld = c;
            if (c == 1) begin
                n_checks++;
                if (busy_a !== 1'b1) begin n_fail++; $display("FAIL ff_busy: got %b, expected 1", busy_a); end
            end
        end
        cycle_a(1'b0, 1'b1);
        n_checks += 7;
        if (first_en != 1 || last_en != 8 || en_cnt != 8) begin
            n_fail++; $display("FAIL ff_issue_window: first=%0d last=%0d count=%0d, expected 1/8/8", first_en, last_en, en_cnt);
        end
        if (first_vld != 4)     begin n_fail++; $display("FAIL ff_latency: first res_valid at %0d, expected 4", first_vld); end
        if (done_cnt_a != 1)    begin n_fail++; $display("FAIL ff_done: %0d pulses, expected 1", done_cnt_a); end
        if (busy_a !== 1'b0)    begin n_fail++; $display("FAIL ff_busy_after: got %b, expected 0", busy_a); end
        if (popped_a != MS_A)   begin n_fail++; $display("FAIL ff_results: got %0d, expected %0d", popped_a, MS_A); end
        if (sb_a.size() != 0)   begin n_fail++; $display("FAIL ff_leftover: %0d expected results not seen, expected 0", sb_a.size()); end
        if (res_valid_a !== 1'b0) begin n_fail++; $display("FAIL ff_idle_valid: got %b, expected 0", res_valid_a); end
    endtask

    task automatic test_backpressure();
        logic [BW-1:0] exp_head;
        exp_head = BW'(-5);
        clear_a();
        for (int c = 0; c < 20; c++) cycle_a(c == 0, 1'b0);
        n_checks += 5;
        if (issued_a != FD_A)        begin n_fail++; $display("FAIL bp_issued: got %0d, expected %0d", issued_a, FD_A); end
        if (row_en_a !== 1'b0)       begin n_fail++; $display("FAIL bp_row_en: got %b, expected 0", row_en_a); end
        if (res_valid_a !== 1'b1)    begin n_fail++; $display("FAIL bp_valid: got %b, expected 1", res_valid_a); end
        if (res_row_a !== 3'd0)      begin n_fail++; $display("FAIL bp_head_row: got %0d, expected 0", res_row_a); end
        if (res_data_a !== exp_head) begin n_fail++; $display("FAIL bp_head_data: got %0d, expected -5", $signed(res_data_a)); end
        for (int c = 0; c < 200 && done_cnt_a == 0; c++) cycle_a(1'b0, 1'b1);
        n_checks += 2;
        if (popped_a != MS_A || sb_a.size() != 0) begin
            n_fail++; $display("FAIL bp_results: got %0d popped, %0d left, expected %0d/0", popped_a, sb_a.size(), MS_A);
        end
        if (done_cnt_a != 1) begin n_fail++; $display("FAIL bp_done: %0d pulses, expected 1", done_cnt_a); end
    endtask

    task automatic test_toggle_ready();
        logic rdy = 1'b0;
        clear_a();
        for (int c = 0; c < 200 && done_cnt_a == 0; c++) begin
            cycle_a(c == 0, rdy);
            rdy = ~rdy;
        end
        n_checks += 2;
        if (popped_a != MS_A || sb_a.size() != 0) begin
            n_fail++; $display("FAIL tog_results: got %0d popped, %0d left, expected %0d/0", popped_a, sb_a.size(), MS_A);
        end
        if (done_cnt_a != 1) begin n_fail++; $display("FAIL tog_done: %0d pulses, expected 1", done_cnt_a); end
    endtask

    task automatic test_start_while_busy();
        logic st = 1'b1;
        clear_a();
        for (int c = 0; c < 100 && done_cnt_a == 0; c++) begin
            cycle_a(st, 1'b1);
            st = row_en_a && (row_idx_a == 3'd2 || row_idx_a == 3'd5);
        end
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        for (int c = 0; c < 5; c++) cycle_a(1'b0, 1'b1);
        n_checks += 3;
        if (issued_a != MS_A)  begin n_fail++; $display("FAIL swb_issued: got %0d, expected %0d", issued_a, MS_A); end
        if (done_cnt_a != 1)   begin n_fail++; $display("FAIL swb_done: %0d pulses, expected 1", done_cnt_a); end
        if (busy_a !== 1'b0)   begin n_fail++; $display("FAIL swb_busy_after: got %b, expected 0", busy_a); end
    endtask

    task automatic test_midjob_reset();
        clear_a();
        for (int c = 0; c < 50 && issued_a < 5; c++) cycle_a(c == 0, 1'b1);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        n_checks += 2;
        if ({busy_a, done_a, row_en_a, row_idx_a, res_valid_a, res_data_a, res_row_a} !== '0) begin
            n_fail++;
            $display("FAIL mr_outputs: busy=%b done=%b row_en=%b row_idx=%0d valid=%b data=%h row=%0d, expected all 0",
                     busy_a, done_a, row_en_a, row_idx_a, res_valid_a, res_data_a, res_row_a);
        end
        if (done_cnt_a != 0) begin n_fail++; $display("FAIL mr_no_done: %0d pulses, expected 0", done_cnt_a); end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        clear_a();
        for (int c = 0; c < 100 && done_cnt_a == 0; c++) cycle_a(c == 0, 1'b1);
        n_checks += 2;
        if (issued_a != MS_A || popped_a != MS_A) begin
            n_fail++; $display("FAIL mr_rerun: issued=%0d popped=%0d, expected %0d", issued_a, popped_a, MS_A);
        end
        if (done_cnt_a != 1) begin n_fail++; $display("FAIL mr_done: %0d pulses, expected 1", done_cnt_a); end
    endtask

    task automatic test_param_sweep();
        int issued_b = 0, popped_b = 0, dones_b = 0;
        logic [IW_B+BW-1:0] exp_e;
        sb_b.delete();
        for (int c = 0; c < 3000 && dones_b == 0; c++) begin
            @(posedge clk);
            #1;
            start_b     = (c == 0);
            res_ready_b = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (row_en_b) begin
                n_checks++;
                if (issued_b >= MS_B || row_idx_b !== IW_B'(issued_b)) begin
                    n_fail++; $display("FAIL issue_b: row_idx=%0d, expected row %0d", row_idx_b, issued_b);
                end
                sb_b.push_back({IW_B'(issued_b), BW'(3 * issued_b - 5)});
                issued_b++;
            end
            if (res_valid_b && res_ready_b) begin
                n_checks++;
                if (sb_b.size() == 0) begin
                    n_fail++; $display("FAIL result_b: unexpected row=%0d, expected none", res_row_b);
                end else begin
                    exp_e = sb_b.pop_front();
                    if ({res_row_b, res_data_b} !== exp_e) begin
                        n_fail++;
                        $display("FAIL result_b: row=%0d data=%0d, expected row=%0d data=%0d", res_row_b,
                                 $signed(res_data_b), exp_e[IW_B+BW-1:BW], $signed(exp_e[BW-1:0]));
                    end
                end
                popped_b++;
            end
            if (row_en_b) begin
                n_checks++;
                if (issued_b - popped_b > FD_B) begin
                    n_fail++; $display("FAIL overflow_b: outstanding=%0d, limit %0d", issued_b - popped_b, FD_B);
                end
            end
            if (done_b) dones_b++;
        end
        n_checks += 2;
        if (issued_b != MS_B || popped_b != MS_B || sb_b.size() != 0) begin
            n_fail++; $display("FAIL sweep_results: issued=%0d popped=%0d left=%0d, expected %0d/%0d/0",
                               issued_b, popped_b, sb_b.size(), MS_B, MS_B);
        end
        if (dones_b != 1) begin n_fail++; $display("FAIL sweep_done: %0d pulses, expected 1", dones_b); end
    endtask

    initial begin
        test_reset();
        test_free_flow();
        test_backpressure();
        test_toggle_ready();
        test_start_while_busy();
        test_midjob_reset();
        test_param_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_tree_sched.md
Name: adder_tree_sched

Overview:
Row scheduler for the pipelined multiply/adder-tree datapath of the vector multiplier.
- On a start pulse, issues MATRIX_SIZE row-compute slots to the datapath, one per cycle when credit allows.
- Tracks each issued row through the fixed datapath latency and captures the tree's final sum into a result FIFO.
- Streams each result, tagged with its row index, to the downstream consumer over a valid/ready handshake.
- The datapath cannot stall, so the block uses credit-based issue to make sure a result is never dropped.

Parameters:
MATRIX_SIZE, 8, rows per job (power of two, >=2)
PARTIAL_SUM_BW, 20, width of the adder-tree sum
PIPE_LAT, 2, cycles from row_en to a valid tree_sum (multiplier register + adder-tree stage), >=1
FIFO_DEPTH, 4, result FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock, all logic on rising edge
rstn  in  1  asynchronous active-low reset
start  in  1  job start pulse; ignored while busy=1
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when the job is fully drained
row_en  out  1  issue strobe to the datapath; its row operands are selected by row_idx
row_idx  out  clog2(MATRIX_SIZE)  row being issued; valid when row_en=1
tree_sum  in  PARTIAL_SUM_BW  signed adder-tree output, sampled PIPE_LAT cycles after row_en
res_valid  out  1  FIFO head valid
res_ready  in  1  consumer ready
res_data  out  PARTIAL_SUM_BW  signed result at the FIFO head
res_row  out  clog2(MATRIX_SIZE)  row index of the FIFO head

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE; row counter, pipeline tracker and FIFO pointers/count cleared.
  - Outputs busy, done, row_en, row_idx, res_valid, res_data and res_row are all 0.
  - Reset mid-job discards every in-flight and buffered result. No done pulse is produced.
- States:
  - IDLE: start=1 -> ISSUE, row counter=0.
  - ISSUE: issue rows under the credit rule below. The cycle row MATRIX_SIZE-1 issues -> DRAIN.
  - DRAIN: wait until inflight=0 and the FIFO is empty -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
  - busy=1 in ISSUE and DRAIN only. A start arriving in DONE is ignored.
- Credit rule:
  - credits = FIFO_DEPTH - fifo_count - inflight, where inflight is the popcount of the tracker.
  - row_en = (state==ISSUE) && (credits>0). Outputs are registered/decoded so that row_en and row_idx change only on a clock edge.
  - Each issue increments row_idx. It never wraps within a job.
  - A pop in the same cycle frees a credit only from the next cycle onward (conservative, no comb path from res_ready to row_en).
- Pipeline tracker:
  - A PIPE_LAT-deep shift register of {valid, row_idx}; row_en/row_idx enter at the tail.
  - When the head valid=1, tree_sum and its row index are pushed into the FIFO in that same cycle.
  - Capture is therefore exactly PIPE_LAT cycles after the matching row_en.
  - The credit rule guarantees the push never finds the FIFO full. An overflow is a design error; the bench asserts on it.
- Result FIFO:
  - First-word-fall-through. res_valid = (count>0).
  - Pop when res_valid && res_ready.
  - Push and pop in the same cycle leave count unchanged and are legal even when count=FIFO_DEPTH (pop side).
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - res_data and res_row are 0 when the FIFO is empty.
- Arithmetic: the scheduler does no arithmetic on the sum. tree_sum is stored bit-exact, including sign.
- Ordering: results leave in row order 0..MATRIX_SIZE-1.

Decomposition:
- Shared package/header vec_mul_pkg: state encodings (IDLE, ISSUE, DRAIN, DONE), clog2 function, default MATRIX_SIZE/PARTIAL_SUM_BW.
- One sub-module, sched_result_fifo: a parameterised width/depth FWFT sync FIFO with count output, with the same async active-low reset.
- Tracker, credit counter and FSM stay in the top module.

Test Plan:
The bench models the datapath as a PIPE_LAT delay line returning tree_sum = 3*row_idx - 5. Defaults apply unless noted.
- Free-flowing, res_ready=1: start -> row_en high 8 consecutive cycles with row_idx 0..7. The first res_valid appears 3 cycles after start is sampled (1 to enter ISSUE + PIPE_LAT). Results -5,-2,1,...,16 appear in order. done pulses once, then busy=0.
- Backpressure, res_ready=0 throughout: exactly 4 rows issue, then row_en stays 0. FIFO holds rows 0..3 with no overflow. Raising res_ready resumes issue; all 8 results arrive in order.
- Simultaneous push/pop with FIFO full: toggle res_ready every cycle. Check count never exceeds 4, no lost or duplicated row, and res_row sequence 0..7.
- Start while busy: pulse start at rows 2 and 5 of a job -> ignored. Exactly 8 issues and one done pulse.
- Mid-job reset: assert rstn=0 after row 4 issues -> all outputs 0 immediately, no done pulse. A new start yields a clean job with rows 0..7.
- Parameter sweep: MATRIX_SIZE=32, PIPE_LAT=1, FIFO_DEPTH=2, random res_ready -> 32 results in order and zero overflow assertions.
